video_ports: RTL and testbench
==============================

Name: video_ports

Overview:
- CPU-side I/O register block feeding the Vector-06C display stage.
- Decodes CPU I/O writes into the display controls: scroll, border, mode512, and a timed palette write strobe plus data.
- Turns the display's retrace output into the frame interrupt request for the CPU.
- Sits between the CPU bus and the video module, in the clk_24m domain.

Parameters:
- PORT_BORDER, 8'h02: I/O address of the border/mode register.
- PORT_SCROLL, 8'h03: I/O address of the scroll register.
- PORT_PAL, 8'h0C: I/O address of the palette write port.
- PAL_DELAY, 4: clk_24m cycles from the accepted palette write to pal_we rising (1..15).
- PAL_WIDTH, 8: pal_we high time in clk_24m cycles (1..15).
- INT_LEN, 1440: maximum vid_int high time in cycles (about 60 us).

Ports:
- clk_24m, input, 1: sole clock, 24 MHz.
- reset, input, 1: asynchronous, active-high reset.
- io_wr, input, 1: one-cycle CPU I/O write strobe.
- io_addr, input, 8: I/O port address, valid with io_wr.
- io_dout, input, 8: CPU write data, valid with io_wr.
- retrace, input, 1: vertical sync from the video stage, asynchronous to this block.
- inte, input, 1: CPU interrupt enable.
- int_ack, input, 1: one-cycle interrupt acknowledge.
- scroll, output, 8: vertical scroll value.
- border, output, 4: border colour index.
- mode512, output, 1: 512-pixel mode select.
- pal_we, output, 1: palette write strobe (io_we of the video stage).
- pal_din, output, 8: palette data; stable while pal_we is high.
- pal_busy, output, 1: a palette write is pending or in progress.
- vid_int, output, 1: frame interrupt request.

Behaviour:

Reset (asynchronous, all registers):
- scroll=8'hFF, border=0, mode512=0, pal_we=0, pal_din=0, pal_busy=0, vid_int=0.
- Palette FSM returns to IDLE; retrace synchroniser cleared.

Register writes:
- A write is io_wr=1 on a clk_24m posedge.
- io_addr==PORT_BORDER: border<=io_dout[3:0], mode512<=io_dout[4]; bits 7:5 ignored.
- io_addr==PORT_SCROLL: scroll<=io_dout.
- Both updates are visible on the next cycle (latency 1).
- Unmatched addresses are ignored.

Palette FSM (states IDLE, DELAY, STROBE; 4-bit counter cnt):
- IDLE: a write to PORT_PAL latches pal_din<=io_dout, sets cnt<=PAL_DELAY-1 and enters DELAY.
- DELAY: cnt decrements each cycle; at cnt==0 go to STROBE, set pal_we<=1, cnt<=PAL_WIDTH-1.
- STROBE: cnt decrements each cycle; at cnt==0 set pal_we<=0 and return to IDLE.
- pal_we is registered. It rises exactly PAL_DELAY cycles after the accepting edge and stays high exactly PAL_WIDTH cycles.
- pal_busy=1 in DELAY and STROBE.
- PORT_PAL write while in DELAY: pal_din is overwritten, cnt reloads PAL_DELAY-1, state stays DELAY (last write wins).
- PORT_PAL write while in STROBE: dropped. pal_din must not change while pal_we=1.
- pal_din holds its value after the strobe ends.

Interrupt:
- retrace passes through a 2-flop synchroniser, then an edge detector.
- Rising edge of the synchronised retrace with inte=1: vid_int<=1 and the 11-bit timeout counter loads INT_LEN-1.
- While vid_int=1 the counter decrements. vid_int clears on int_ack=1 or when the counter reaches 0 (high at most INT_LEN cycles).
- Rising edge with inte=0: no request.
- inte falling while vid_int=1: no effect.
- A new edge in the same cycle as int_ack or timeout: set wins, counter reloads.
- A second edge while vid_int=1: counter reloads.
- Latency: vid_int is high 3 cycles after retrace rises (2 synchroniser stages plus the register).

Simultaneous events:
- Register writes and palette/interrupt activity are independent.
- A border write during a palette strobe takes effect normally.

Reset mid-operation:
- Aborts the palette strobe: pal_we drops asynchronously, no partial write is retried.
- Clears vid_int.

Test Plan:
1. Reset, then check outputs: scroll=FF, border=0, mode512=0, pal_we=0, vid_int=0. Write 8'h15 to 02 -> border=5, mode512=1 next cycle. Write 8'hA0 to 03 -> scroll=A0.
2. Write 8'h3C to 0C at cycle T -> pal_din=3C at T+1; pal_we high on cycles T+4..T+11 exactly; pal_busy high T+1..T+11.
3. Write 11 to 0C at T and 22 at T+2 -> single pal_we pulse starting T+6 with pal_din=22. Write 33 during STROBE -> ignored, pal_din stays 22.
4. inte=1, raise retrace -> vid_int rises 3 cycles later. int_ack 10 cycles later -> vid_int low next cycle. No ack -> vid_int high exactly 1440 cycles.
5. inte=0, retrace edge -> vid_int stays 0. Retrace edge coincident with int_ack -> vid_int stays 1 and the counter restarts.
6. Assert reset during STROBE and with vid_int=1 -> pal_we=0 and vid_int=0 immediately. After release, the FSM is IDLE and the next 0C write behaves as in scenario 2.

Source files
------------

// File: rtl/video_ports.sv
// CPU I/O register block for the Vector-06C display stage: scroll/border/mode
// registers, a timed palette write strobe, and the frame interrupt request.
module video_ports #(
  parameter logic [7:0] PORT_BORDER = 8'h02,
  parameter logic [7:0] PORT_SCROLL = 8'h03,
  parameter logic [7:0] PORT_PAL    = 8'h0C,
  parameter int unsigned PAL_DELAY  = 4,
  parameter int unsigned PAL_WIDTH  = 8,
  parameter int unsigned INT_LEN    = 1440
) (
  input  logic       clk_24m,
  input  logic       reset,
  input  logic       io_wr,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_dout,
  input  logic       retrace,
  input  logic       inte,
  input  logic       int_ack,
  output logic [7:0] scroll,
  output logic [3:0] border,
  output logic       mode512,
  output logic       pal_we,
  output logic [7:0] pal_din,
  output logic       pal_busy,
  output logic       vid_int
);

  localparam logic [3:0]  DELAY_LOAD = 4'(PAL_DELAY - 1);
  localparam logic [3:0]  WIDTH_LOAD = 4'(PAL_WIDTH - 1);
  localparam logic [10:0] INT_LOAD   = 11'(INT_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_STROBE} pal_state_t;

  pal_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pal_we_q, pal_we_d;
  logic [7:0]  pal_din_q, pal_din_d;
  logic [7:0]  scroll_q, scroll_d;
  logic [3:0]  border_q, border_d;
  logic        mode512_q, mode512_d;
  logic        rtr_s1_q, rtr_s1_d;
  logic        rtr_s2_q, rtr_s2_d;
  logic        rtr_prev_q, rtr_prev_d;
  logic        vid_int_q, vid_int_d;
  logic [10:0] int_cnt_q, int_cnt_d;
  logic        pal_wr;
  logic        rtr_rise;

  always_comb begin
    scroll_d  = scroll_q;
    border_d  = border_q;
    mode512_d = mode512_q;
    if (io_wr && io_addr == PORT_BORDER) begin
      border_d  = io_dout[3:0];
      mode512_d = io_dout[4];
    end
    if (io_wr && io_addr == PORT_SCROLL) scroll_d = io_dout;
  end

  // A write during DELAY restarts the delay with new data; during STROBE it is
  // dropped so pal_din never changes under a high pal_we.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pal_we_d  = pal_we_q;
    pal_din_d = pal_din_q;
    pal_wr    = io_wr && (io_addr == PORT_PAL);
    case (state_q)
      ST_IDLE: begin
        if (pal_wr) begin
          pal_din_d = io_dout;
          cnt_d     = DELAY_LOAD;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (pal_wr) begin
          pal_din_d = io_dout;
          cnt_d     = DELAY_LOAD;
        end else if (cnt_q == '0) begin
          state_d  = ST_STROBE;
          pal_we_d = 1'b1;
          cnt_d    = WIDTH_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          pal_we_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pal_we_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rtr_s1_d   = retrace;
    rtr_s2_d   = rtr_s1_q;
    rtr_prev_d = rtr_s2_q;
    rtr_rise   = rtr_s2_q & ~rtr_prev_q;
    vid_int_d  = vid_int_q;
    int_cnt_d  = int_cnt_q;
    // A new edge beats a coincident ack or timeout and restarts the window.
    if (rtr_rise && inte) begin
      vid_int_d = 1'b1;
      int_cnt_d = INT_LOAD;
    end else if (vid_int_q) begin
      if (int_ack || int_cnt_q == '0) vid_int_d = 1'b0;
      else                            int_cnt_d = int_cnt_q - 11'd1;
    end
  end

  always_ff @(posedge clk_24m or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pal_we_q   <= 1'b0;
      pal_din_q  <= '0;
      scroll_q   <= '1;
      border_q   <= '0;
      mode512_q  <= 1'b0;
      rtr_s1_q   <= 1'b0;
      rtr_s2_q   <= 1'b0;
      rtr_prev_q <= 1'b0;
      vid_int_q  <= 1'b0;
      int_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pal_we_q   <= pal_we_d;
      pal_din_q  <= pal_din_d;
      scroll_q   <= scroll_d;
      border_q   <= border_d;
      mode512_q  <= mode512_d;
      rtr_s1_q   <= rtr_s1_d;
      rtr_s2_q   <= rtr_s2_d;
      rtr_prev_q <= rtr_prev_d;
      vid_int_q  <= vid_int_d;
      int_cnt_q  <= int_cnt_d;
    end
  end

  assign scroll   = scroll_q;
  assign border   = border_q;
  assign mode512  = mode512_q;
  assign pal_we   = pal_we_q;
  assign pal_din  = pal_din_q;
  assign pal_busy = (state_q != ST_IDLE);
  assign vid_int  = vid_int_q;

endmodule

// File: tb/tb_video_ports.sv
// Directed bench for video_ports: register writes, palette strobe timing,
// frame interrupt timing/ack/timeout and mid-operation reset.
module tb_video_ports;

  logic       clk_24m = 1'b0;
  logic       reset   = 1'b1;
  logic       io_wr   = 1'b0;
  logic [7:0] io_addr = '0;
  logic [7:0] io_dout = '0;
  logic       retrace = 1'b0;
  logic       inte    = 1'b0;
  logic       int_ack = 1'b0;
  logic [7:0] scroll;
  logic [3:0] border;
  logic       mode512;
  logic       pal_we;
  logic [7:0] pal_din;
  logic       pal_busy;
  logic       vid_int;

  int unsigned vectors = 0;
  int unsigned errs    = 0;
  int unsigned n;

  video_ports #(
    .PORT_BORDER(8'h02),
    .PORT_SCROLL(8'h03),
    .PORT_PAL   (8'h0C),
    .PAL_DELAY  (4),
    .PAL_WIDTH  (8),
    .INT_LEN    (1440)
  ) dut (
    .clk_24m (clk_24m),
    .reset   (reset),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .retrace (retrace),
    .inte    (inte),
    .int_ack (int_ack),
    .scroll  (scroll),
    .border  (border),
    .mode512 (mode512),
    .pal_we  (pal_we),
    .pal_din (pal_din),
    .pal_busy(pal_busy),
    .vid_int (vid_int)
  );

  always #5 clk_24m = ~clk_24m;

  task automatic step();
    @(posedge clk_24m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr = a;
    io_dout = d;
    io_wr   = 1'b1;
    step();
    io_wr   = 1'b0;
  endtask

  // Write d to the palette port, then follow the strobe edge by edge.
  task automatic pal_pulse(input logic [7:0] d, input bit with_border);
    wr(8'h0C, d);
    chk("pal_din_e0", 32'(pal_din), 32'(d));
    chk("pal_busy_e0", 32'(pal_busy), 32'd1);
    chk("pal_we_e0", 32'(pal_we), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      io_wr   = with_border && (k == 6);
      io_addr = 8'h02;
      io_dout = 8'hEA;
      step();
      io_wr = 1'b0;
      chk($sformatf("pal_we_e%0d", k), 32'(pal_we), 32'(k >= 4 && k <= 11));
      chk($sformatf("pal_busy_e%0d", k), 32'(pal_busy), 32'(k <= 11));
      chk($sformatf("pal_din_e%0d", k), 32'(pal_din), 32'(d));
      if (with_border && k == 6) begin
        chk("border_in_strobe", 32'(border), 32'hA);
        chk("mode512_in_strobe", 32'(mode512), 32'd0);
      end
    end
  endtask

  // Counts cycles vid_int stays high, including the current one.
  task automatic count_high(output int unsigned cnt);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (vid_int) cnt++;
      else break;
    end
  endtask

  initial begin
    // 1: reset state and register writes
    step();
    step();
    chk("rst_scroll", 32'(scroll), 32'hFF);
    chk("rst_border", 32'(border), 32'h0);
    chk("rst_mode512", 32'(mode512), 32'd0);
    chk("rst_pal_we", 32'(pal_we), 32'd0);
    chk("rst_pal_din", 32'(pal_din), 32'h0);
    chk("rst_pal_busy", 32'(pal_busy), 32'd0);
    chk("rst_vid_int", 32'(vid_int), 32'd0);
    @(negedge clk_24m);
    reset = 1'b0;
    step();
    wr(8'h02, 8'h15);
    chk("border_wr", 32'(border), 32'h5);
    chk("mode512_wr", 32'(mode512), 32'd1);
    wr(8'h03, 8'hA0);
    chk("scroll_wr", 32'(scroll), 32'hA0);
    wr(8'h05, 8'h00);
    chk("unmatched_scroll", 32'(scroll), 32'hA0);
    chk("unmatched_border", 32'(border), 32'h5);
    chk("unmatched_busy", 32'(pal_busy), 32'd0);

    // 2: single palette write, border write mid-strobe
    pal_pulse(8'h3C, 1'b1);

    // 3: rewrite during DELAY wins, write during STROBE dropped
    wr(8'h0C, 8'h11);
    chk("pal3_din_e0", 32'(pal_din), 32'h11);
    for (int k = 1; k <= 14; k++) begin
      io_wr   = (k == 2) || (k == 8);
      io_addr = 8'h0C;
      io_dout = (k == 2) ? 8'h22 : 8'h33;
      step();
      io_wr = 1'b0;
      chk($sformatf("pal3_we_e%0d", k), 32'(pal_we), 32'(k >= 6 && k <= 13));
      chk($sformatf("pal3_din_e%0d", k), 32'(pal_din), (k >= 2) ? 32'h22 : 32'h11);
    end

    // 4: interrupt latency, ack, timeout
    inte    = 1'b1;
    retrace = 1'b1;
    step();
    chk("int_lat_e1", 32'(vid_int), 32'd0);
    step();
    chk("int_lat_e2", 32'(vid_int), 32'd0);
    step();
    chk("int_lat_e3", 32'(vid_int), 32'd1);
    for (int i = 0; i < 9; i++) step();
    chk("int_before_ack", 32'(vid_int), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("int_after_ack", 32'(vid_int), 32'd0);
    retrace = 1'b0;
    for (int i = 0; i < 3; i++) step();
    retrace = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("int_rise2", 32'(vid_int), 32'd1);
    count_high(n);
    chk("int_timeout_len", 32'(n), 32'd1440);

    // 5: edge with inte=0, edge coincident with ack
    retrace = 1'b0;
    for (int i = 0; i < 4; i++) step();
    inte    = 1'b0;
    retrace = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("int_masked", 32'(vid_int), 32'd0);
    retrace = 1'b0;
    for (int i = 0; i < 4; i++) step();
    inte    = 1'b1;
    retrace = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("int_rise3", 32'(vid_int), 32'd1);
    retrace = 1'b0;
    for (int i = 0; i < 3; i++) step();
    retrace = 1'b1;
    step();
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("int_set_beats_ack", 32'(vid_int), 32'd1);
    count_high(n);
    chk("int_reload_len", 32'(n), 32'd1440);

    // 6: reset during strobe with vid_int high
    retrace = 1'b0;
    for (int i = 0; i < 3; i++) step();
    retrace = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("int_rise4", 32'(vid_int), 32'd1);
    wr(8'h0C, 8'h5A);
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_we", 32'(pal_we), 32'd1);
    #2;
    reset   = 1'b1;
    retrace = 1'b0;
    #1;
    chk("async_rst_we", 32'(pal_we), 32'd0);
    chk("async_rst_int", 32'(vid_int), 32'd0);
    chk("async_rst_busy", 32'(pal_busy), 32'd0);
    chk("async_rst_scroll", 32'(scroll), 32'hFF);
    chk("async_rst_din", 32'(pal_din), 32'h0);
    step();
    step();
    @(negedge clk_24m);
    reset = 1'b0;
    step();
    chk("post_rst_busy", 32'(pal_busy), 32'd0);
    pal_pulse(8'h7E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
